// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - panel ID codes, per-panel timing records and the ID-to-timing lookup
package lcd_pkg;

  localparam logic [2:0] ID_4342 = 3'b000;
  localparam logic [2:0] ID_7084 = 3'b001;
  localparam logic [2:0] ID_7016 = 3'b010;
  localparam logic [2:0] ID_4384 = 3'b100;
  localparam logic [2:0] ID_1018 = 3'b101;

  localparam logic [23:0] RGB_WHITE = 24'hFFFFFF;
  localparam logic [23:0] RGB_BLACK = 24'h000000;
  localparam logic [23:0] RGB_RED   = 24'hFF0000;
  localparam logic [23:0] RGB_GREEN = 24'h00FF00;
  localparam logic [23:0] RGB_BLUE  = 24'h0000FF;

  typedef enum logic [1:0] {BOOT_RESET, BOOT_ID_WAIT, BOOT_RUN} boot_state_t;

  typedef struct packed {
    logic [11:0] h_sync;
    logic [11:0] h_back;
    logic [11:0] h_disp;
    logic [11:0] h_front;
    logic [11:0] h_total;
    logic [11:0] v_sync;
    logic [11:0] v_back;
    logic [11:0] v_disp;
    logic [11:0] v_front;
    logic [11:0] v_total;
    logic [2:0]  div;
  } lcd_timing_t;

  function automatic lcd_timing_t make_timing(input int hs, input int hb, input int hd,
                                              input int hf, input int ht, input int vs,
                                              input int vb, input int vd, input int vf,
                                              input int vt, input int dv);
    lcd_timing_t t;
    t.h_sync  = 12'(hs);
    t.h_back  = 12'(hb);
    t.h_disp  = 12'(hd);
    t.h_front = 12'(hf);
    t.h_total = 12'(ht);
    t.v_sync  = 12'(vs);
    t.v_back  = 12'(vb);
    t.v_disp  = 12'(vd);
    t.v_front = 12'(vf);
    t.v_total = 12'(vt);
    t.div     = 3'(dv);
    return t;
  endfunction

  // Unknown straps fall back to the 480x272 panel.
  function automatic lcd_timing_t id_to_timing(input logic [2:0] id);
    lcd_timing_t t;
    case (id)
      ID_7084, ID_4384: t = make_timing(128, 88, 800, 40, 1056, 2, 33, 480, 10, 525, 2);
      ID_7016:          t = make_timing(20, 140, 1024, 160, 1344, 3, 20, 600, 12, 635, 1);
      ID_1018:          t = make_timing(10, 80, 1280, 70, 1440, 3, 10, 800, 10, 823, 1);
      ID_4342:          t = make_timing(41, 2, 480, 2, 525, 10, 2, 272, 2, 286, 4);
      default:          t = make_timing(41, 2, 480, 2, 525, 10, 2, 272, 2, 286, 4);
    endcase
    return t;
  endfunction

endpackage

// File: rtl/lcd_rgb_colorbar_if.sv
// rtl/lcd_rgb_colorbar_if.sv - link between the top (pixel enable, timing record) and the timing generator
interface lcd_rgb_colorbar_if;
  import lcd_pkg::*;

  logic        pix_en;
  lcd_timing_t tim;
  logic        de;
  logic        hs;
  logic        vs;
  logic [11:0] x;

  modport master (input pix_en, input tim, output de, output hs, output vs, output x);
  modport slave  (output pix_en, output tim, input de, input hs, input vs, input x);

endinterface

// File: rtl/lcd_rgb_colorbar_timing_gen.sv
// rtl/lcd_rgb_colorbar_timing_gen.sv - lcd_timing_gen: h/v counters and registered de/hs/vs
// Sync pulses are generated only when LCD_HVSYNC_EN is defined; otherwise hs/vs stay high.
module lcd_timing_gen
  import lcd_pkg::*;
(
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  lcd_rgb_colorbar_if.master tif
);

  logic [11:0] h_cnt;
  logic [11:0] v_cnt;
  logic [11:0] h_start;
  logic [11:0] v_start;
  logic        h_active;
  logic        v_active;
  logic        de_r;

  assign h_start  = tif.tim.h_sync + tif.tim.h_back;
  assign v_start  = tif.tim.v_sync + tif.tim.v_back;
  assign h_active = (h_cnt >= h_start) && (h_cnt < h_start + tif.tim.h_disp);
  assign v_active = (v_cnt >= v_start) && (v_cnt < v_start + tif.tim.v_disp);
  // Unregistered so the top can register the pixel on the same enable as de.
  assign tif.x    = h_cnt - h_start;
  assign tif.de   = de_r;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
      de_r  <= 1'b0;
    end else if (tif.pix_en) begin
      de_r <= h_active && v_active;
      if (h_cnt == tif.tim.h_total - 12'd1) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == tif.tim.v_total - 12'd1) ? 12'd0 : v_cnt + 12'd1;
      end else begin
        h_cnt <= h_cnt + 12'd1;
      end
    end
  end

`ifdef LCD_HVSYNC_EN
  logic hs_r;
  logic vs_r;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      hs_r <= 1'b1;
      vs_r <= 1'b1;
    end else if (tif.pix_en) begin
      hs_r <= (h_cnt >= tif.tim.h_sync);
      vs_r <= (v_cnt >= tif.tim.v_sync);
    end
  end

  assign tif.hs = hs_r;
  assign tif.vs = vs_r;
`else
  assign tif.hs = 1'b1;
  assign tif.vs = 1'b1;
`endif

endmodule

// File: rtl/lcd_rgb_colorbar.sv
// rtl/lcd_rgb_colorbar.sv - RGB LCD top: ID strap read, pixel clock, five colour bars
// Optional sync generation via LCD_HVSYNC_EN (see lcd_timing_gen).
module lcd_rgb_colorbar
  import lcd_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  output logic        lcd_clk,
  output logic        lcd_de,
  inout  wire  [23:0] lcd_rgb,
  output logic        lcd_bl,
  output logic        lcd_rst,
  output logic        lcd_hs,
  output logic        lcd_vs
);

  lcd_rgb_colorbar_if tif ();

  boot_state_t state;
  boot_state_t state_nxt;
  logic        id_load;
  logic        running;
  logic [2:0]  id;
  logic        div_cnt;
  logic        clk_r;
  logic        tick;
  logic        div1;
  logic [11:0] bar_w;
  logic [11:0] bar_w2;
  logic [11:0] bar_w3;
  logic [11:0] bar_w4;
  logic [23:0] pixel;
  logic [23:0] pixel_nxt;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) state <= BOOT_RESET;
    else            state <= state_nxt;
  end

  // The ID is taken on the second clock after reset release, then never again.
  always_comb begin
    state_nxt = state;
    id_load   = 1'b0;
    case (state)
      BOOT_RESET:   state_nxt = BOOT_ID_WAIT;
      BOOT_ID_WAIT: begin
        state_nxt = BOOT_RUN;
        id_load   = 1'b1;
      end
      BOOT_RUN:     state_nxt = BOOT_RUN;
      default:      state_nxt = BOOT_RESET;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      id      <= 3'b000;
      lcd_rst <= 1'b0;
    end else if (id_load) begin
      id      <= {lcd_rgb[7], lcd_rgb[15], lcd_rgb[23]};
      lcd_rst <= 1'b1;
    end
  end

  assign tif.tim    = id_to_timing(id);
  assign running    = (state == BOOT_RUN);
  assign div1       = (tif.tim.div == 3'd1);
  assign tick       = (tif.tim.div == 3'd4) ? div_cnt : 1'b1;
  // Pixel enable lands on the sys_clk edge where lcd_clk falls; panel samples on the rise.
  assign tif.pix_en = running && (div1 || (tick && clk_r));
  assign lcd_clk    = div1 ? sys_clk : clk_r;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      div_cnt <= 1'b0;
      clk_r   <= 1'b0;
      lcd_bl  <= 1'b0;
      pixel   <= '0;
    end else begin
      if (running) begin
        div_cnt <= ~div_cnt;
        if (tick) clk_r <= ~clk_r;
      end
      if (tif.pix_en) begin
        lcd_bl <= 1'b1;
        pixel  <= pixel_nxt;
      end
    end
  end

  assign bar_w  = tif.tim.h_disp / 12'd5;
  assign bar_w2 = bar_w + bar_w;
  assign bar_w3 = bar_w2 + bar_w;
  assign bar_w4 = bar_w2 + bar_w2;

  always_comb begin
    pixel_nxt = RGB_BLUE;
    if (tif.x < bar_w)       pixel_nxt = RGB_WHITE;
    else if (tif.x < bar_w2) pixel_nxt = RGB_BLACK;
    else if (tif.x < bar_w3) pixel_nxt = RGB_RED;
    else if (tif.x < bar_w4) pixel_nxt = RGB_GREEN;
  end

  lcd_timing_gen u_timing_gen (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .tif       (tif)
  );

  assign lcd_de  = tif.de;
  assign lcd_hs  = tif.hs;
  assign lcd_vs  = tif.vs;
  assign lcd_rgb = lcd_de ? pixel : 24'hz;

endmodule

// File: tb/tb_lcd_rgb_colorbar.sv
// tb/tb_lcd_rgb_colorbar.sv - bench for lcd_rgb_colorbar: ID straps, bars, tri-state, mid-frame reset
`timescale 1ns/1ps
module tb_lcd_rgb_colorbar;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        lcd_clk;
  logic        lcd_de;
  logic        lcd_bl;
  logic        lcd_rst;
  logic        lcd_hs;
  logic        lcd_vs;
  wire  [23:0] lcd_rgb;
  logic [23:0] strap = 24'h000080;

  assign lcd_rgb = lcd_de ? 24'hz : strap;

  always #10 sys_clk = ~sys_clk;

  lcd_rgb_colorbar dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .lcd_clk   (lcd_clk),
    .lcd_de    (lcd_de),
    .lcd_rgb   (lcd_rgb),
    .lcd_bl    (lcd_bl),
    .lcd_rst   (lcd_rst),
    .lcd_hs    (lcd_hs),
    .lcd_vs    (lcd_vs)
  );

`ifdef LCD_HVSYNC_EN
  localparam bit HVSYNC = 1'b1;
`else
  localparam bit HVSYNC = 1'b0;
`endif

  typedef struct {
    int hs, hb, hd, ht, vs, vb, vd, vt, dv;
  } mode_t;

  function automatic mode_t mode_of(input int id);
    mode_t m;
    case (id)
      1, 4:    m = '{128, 88, 800, 1056, 2, 33, 480, 525, 2};
      2:       m = '{20, 140, 1024, 1344, 3, 20, 600, 635, 1};
      5:       m = '{10, 80, 1280, 1440, 3, 10, 800, 823, 1};
      default: m = '{41, 2, 480, 525, 10, 2, 272, 286, 4};
    endcase
    return m;
  endfunction

  logic [23:0] bar_rgb [5] = '{24'hFFFFFF, 24'h000000, 24'hFF0000, 24'h00FF00, 24'h0000FF};

  // Hand-computed ID 000 pins on active line 12: {h, de, rgb}
  int          pin_h   [12] = '{42, 43, 138, 139, 234, 235, 330, 331, 426, 427, 522, 523};
  logic        pin_de  [12] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  logic [23:0] pin_rgb [12] = '{24'h0, 24'hFFFFFF, 24'hFFFFFF, 24'h0, 24'h0, 24'hFF0000,
                                24'hFF0000, 24'h00FF00, 24'h00FF00, 24'h0000FF, 24'h0000FF, 24'h0};

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  int exp_id        = 4;
  int exp_de_line   = 800;
  int exp_hs_low    = 0;
  int vs_check_line = 3;
  int exp_vs_lines  = 0;

  logic rst_q    = 1'b0;
  int   post_cnt = 0;

  initial begin
    forever begin
      @(posedge sys_clk);
      rst_q    = sys_rst_n;
      post_cnt = sys_rst_n ? post_cnt + 1 : 0;
    end
  end

  int      rises    = 0;
  logic    prev_clk = 1'b0;
  realtime last_rise = 0.0;
  int      cur_h    = -1;
  int      cur_v    = -1;
  int      line_de  = 0;
  int      line_hs  = 0;
  int      vs_lines = 0;

  initial begin
    mode_t       m;
    int          p, h, v, x, bi;
    logic        act;
    logic        e_hs, e_vs;
    logic [23:0] e_rgb;
    forever begin
      @(negedge sys_clk);
      if (!rst_q) begin
        check("rst_de", lcd_de, 0);
        check("rst_rgb", lcd_rgb, strap);
        check("rst_bl", lcd_bl, 0);
        check("rst_lcd_rst", lcd_rst, 0);
        check("rst_hs", lcd_hs, 1);
        check("rst_vs", lcd_vs, 1);
        check("rst_clk", lcd_clk, 0);
        rises = 0; prev_clk = 1'b0; cur_h = -1; cur_v = -1;
        line_de = 0; line_hs = 0; vs_lines = 0;
      end else begin
        check("lcd_rst", lcd_rst, post_cnt >= 2);
        if (lcd_clk === 1'b1 && prev_clk == 1'b0) begin
          rises++;
          m = mode_of(exp_id);
          if (rises == 1) begin
            check("pre_de", lcd_de, 0);
            check("pre_rgb", lcd_rgb, strap);
            check("pre_hs", lcd_hs, 1);
            check("pre_vs", lcd_vs, 1);
            check("pre_bl", lcd_bl, 0);
          end else begin
            p   = rises - 2;
            h   = p % m.ht;
            v   = (p / m.ht) % m.vt;
            x   = h - (m.hs + m.hb);
            act = (x >= 0) && (x < m.hd) && (v >= m.vs + m.vb) && (v < m.vs + m.vb + m.vd);
            bi  = act ? x / (m.hd / 5) : 0;
            if (bi > 4) bi = 4;
            e_rgb = act ? bar_rgb[bi] : strap;
            e_hs  = HVSYNC ? (h >= m.hs) : 1'b1;
            e_vs  = HVSYNC ? (v >= m.vs) : 1'b1;
            if (rises >= 3)
              check("lcd_clk_period_ns", $rtoi($realtime - last_rise), m.dv * 20);
            if (h == 0 && rises > 2) begin
              if (line_de != 0) check("de_per_line", line_de, exp_de_line);
              check("hs_low_per_line", line_hs, exp_hs_low);
              line_de = 0;
              line_hs = 0;
            end
            if (h == 0 && v == vs_check_line) check("vs_low_lines", vs_lines, exp_vs_lines);
            if (h == 0 && lcd_vs === 1'b0) vs_lines++;
            if (lcd_de === 1'b1) line_de++;
            if (lcd_hs === 1'b0) line_hs++;
            check("de", lcd_de, act);
            check("rgb", lcd_rgb, e_rgb);
            check("hs", lcd_hs, e_hs);
            check("vs", lcd_vs, e_vs);
            check("bl", lcd_bl, 1);
            if (exp_id == 0 && v == 12) begin
              for (int k = 0; k < 12; k++) begin
                if (h == pin_h[k]) begin
                  check("pin_de", lcd_de, pin_de[k]);
                  check("pin_rgb", lcd_rgb, pin_rgb[k]);
                end
              end
            end
            cur_h = h;
            cur_v = v;
          end
          last_rise = $realtime;
        end
        prev_clk = lcd_clk;
      end
    end
  end

  task automatic wait_pos(input int tv, input int th, input int bound, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(posedge sys_clk);
      if (cur_v == tv && cur_h == th) begin
        hit = 1'b1;
        break;
      end
    end
    check(name, hit, 1);
  endtask

  initial begin
    // ID 100: 800x480, div 2
    strap         = 24'h000080;
    exp_id        = 4;
    exp_de_line   = 800;
    exp_hs_low    = HVSYNC ? 128 : 0;
    vs_check_line = 3;
    exp_vs_lines  = HVSYNC ? 2 : 0;
    repeat (5) @(posedge sys_clk);
    #2 sys_rst_n = 1'b1;
    wait_pos(3, 200, 10000, "reach_id100_line3");

    // ID 000: 480x272, div 4, run into the active area
    #2 sys_rst_n = 1'b0;
    strap         = 24'h000000;
    exp_id        = 0;
    exp_de_line   = 480;
    exp_hs_low    = HVSYNC ? 41 : 0;
    vs_check_line = 12;
    exp_vs_lines  = HVSYNC ? 10 : 0;
    repeat (5) @(posedge sys_clk);
    #2 sys_rst_n = 1'b1;
    wait_pos(13, 200, 35000, "reach_id000_active_line13");

    // Reset in the middle of an active line, then re-strap to ID 001
    #2 sys_rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    #2 strap      = 24'h800000;
    exp_id        = 1;
    exp_de_line   = 800;
    exp_hs_low    = HVSYNC ? 128 : 0;
    vs_check_line = 3;
    exp_vs_lines  = HVSYNC ? 2 : 0;
    sys_rst_n     = 1'b1;
    wait_pos(3, 10, 10000, "reach_id001_line3");

    repeat (4) @(posedge sys_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
